// File: rtl/ir_tx_pkg.sv
// Shared types and constants for the IR transmit sequencer.
// Holds the coding-mode and FSM-state enums plus the input clamp helpers.
package ir_tx_pkg;

  typedef enum logic [1:0] {
    MODE_BIPHASE = 2'd0,
    MODE_PDIST   = 2'd1,
    MODE_PLEN    = 2'd2,
    MODE_ILLEGAL = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEG1 = 2'd1,
    ST_SEG2 = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [15:0] MIN_DIV  = 16'd4;
  localparam logic [5:0]  MAX_BITS = 6'd32;

  function automatic logic [15:0] clamp_div(input logic [15:0] div);
    return (div < MIN_DIV) ? MIN_DIV : div;
  endfunction

  function automatic logic [5:0] clamp_nbits(input logic [5:0] nbits);
    return (nbits > MAX_BITS) ? MAX_BITS : nbits;
  endfunction

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier generator: free-running period counter with 25% duty output and
// a one-cycle tick on the last count of each period.
module ir_carrier_gen (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_clr,
  input  logic [15:0] i_div,
  output logic        o_carrier,
  output logic        o_tick
);

  logic [15:0] r_cnt;
  logic [15:0] w_last;

  assign w_last    = i_div - 16'd1;
  assign o_tick    = (r_cnt == w_last);
  assign o_carrier = (r_cnt < (i_div >> 2));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= 16'd0;
    end else if (i_clr || o_tick) begin
      r_cnt <= 16'd0;
    end else begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

endmodule

// File: rtl/ir_tx_sequencer.sv
// IR frame transmitter: serialises a captured payload LSB first as two
// segments per bit (bi-phase, pulse-distance or pulse-length coding).
module ir_tx_sequencer
  import ir_tx_pkg::*;
#(
  parameter int P_HALF  = 32,
  parameter int P_SHORT = 32,
  parameter int P_LONG  = 64
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  input  logic [1:0]  i_mode,
  input  logic [31:0] i_data,
  input  logic [5:0]  i_nbits,
  input  logic [15:0] i_carrier_div,
  input  logic        i_abort,
  output logic        o_ir_dout,
  output logic        o_ready,
  output logic        o_done,
  output logic        o_err
);

  localparam logic [6:0] L_HALF  = 7'(P_HALF);
  localparam logic [6:0] L_SHORT = 7'(P_SHORT);
  localparam logic [6:0] L_LONG  = 7'(P_LONG);

  state_e      r_state;
  state_e      w_state_nxt;
  mode_e       r_mode;
  logic [31:0] r_shift;
  logic [5:0]  r_bits;
  logic [15:0] r_div;
  logic [6:0]  r_seg_cnt;
  logic        r_err;

  logic        w_accept;
  logic        w_legal;
  logic [5:0]  w_nbits_c;
  logic        w_in_seg;
  logic        w_bit;
  logic        w_mark;
  logic [6:0]  w_seg_len;
  logic        w_seg_end;
  logic        w_last_bit;
  logic        w_carrier;
  logic        w_tick;
  logic        w_carrier_clr;

  assign w_accept   = i_start && (r_state == ST_IDLE);
  assign w_legal    = (i_mode != MODE_ILLEGAL);
  assign w_nbits_c  = clamp_nbits(i_nbits);
  assign w_in_seg   = (r_state == ST_SEG1) || (r_state == ST_SEG2);
  assign w_bit      = r_shift[0];
  assign w_last_bit = (r_bits == 6'd1);
  assign w_seg_end  = w_in_seg && w_tick && (r_seg_cnt == (w_seg_len - 7'd1));

  // Carrier restarts at count 0 at every segment boundary and is held in reset outside segments.
  assign w_carrier_clr = !w_in_seg || w_seg_end || i_abort;

  ir_carrier_gen u_carrier (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_clr    (w_carrier_clr),
    .i_div    (r_div),
    .o_carrier(w_carrier),
    .o_tick   (w_tick)
  );

  // Segment polarity and length for the bit at the head of the shift register.
  always_comb begin
    w_seg_len = L_SHORT;
    w_mark    = 1'b0;
    case (r_mode)
      MODE_BIPHASE: begin
        w_seg_len = L_HALF;
        w_mark    = (r_state == ST_SEG1) ? !w_bit : w_bit;
      end
      MODE_PDIST: begin
        if (r_state == ST_SEG1) begin
          w_mark = 1'b1;
        end else begin
          w_seg_len = w_bit ? L_LONG : L_SHORT;
        end
      end
      MODE_PLEN: begin
        if (r_state == ST_SEG1) begin
          w_mark    = 1'b1;
          w_seg_len = w_bit ? L_LONG : L_SHORT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    o_ready     = 1'b0;
    o_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_ready = 1'b1;
        if (w_accept && w_legal) begin
          w_state_nxt = (w_nbits_c == 6'd0) ? ST_DONE : ST_SEG1;
        end
      end
      ST_SEG1: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_seg_end) begin
          w_state_nxt = ST_SEG2;
        end
      end
      ST_SEG2: begin
        if (i_abort) begin
          w_state_nxt = ST_IDLE;
        end else if (w_seg_end) begin
          w_state_nxt = w_last_bit ? ST_DONE : ST_SEG1;
        end
      end
      ST_DONE: begin
        o_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mode    <= MODE_BIPHASE;
      r_shift   <= 32'd0;
      r_bits    <= 6'd0;
      r_div     <= 16'd0;
      r_seg_cnt <= 7'd0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_accept && !w_legal;
      if (w_accept && w_legal) begin
        r_mode    <= mode_e'(i_mode);
        r_shift   <= i_data;
        r_bits    <= w_nbits_c;
        r_div     <= clamp_div(i_carrier_div);
        r_seg_cnt <= 7'd0;
      end else if (w_in_seg) begin
        if (i_abort || w_seg_end) begin
          r_seg_cnt <= 7'd0;
        end else if (w_tick) begin
          r_seg_cnt <= r_seg_cnt + 7'd1;
        end
        if (!i_abort && w_seg_end && (r_state == ST_SEG2)) begin
          r_shift <= r_shift >> 1;
          r_bits  <= r_bits - 6'd1;
        end
      end
    end
  end

  // Gated by reset directly so the line drops without waiting for any edge.
  assign o_ir_dout = i_rst_n && w_in_seg && w_mark && w_carrier;
  assign o_err     = r_err;

endmodule

// File: tb/tb_ir_tx_sequencer.sv
// Self-checking bench for ir_tx_sequencer: directed and random frames compared
// cycle by cycle against a waveform model built from the coding rules.
module tb_ir_tx_sequencer;

  localparam int T_HALF  = 32;
  localparam int T_SHORT = 32;
  localparam int T_LONG  = 64;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_start;
  logic [1:0]  i_mode;
  logic [31:0] i_data;
  logic [5:0]  i_nbits;
  logic [15:0] i_carrier_div;
  logic        i_abort;
  logic        o_ir_dout;
  logic        o_ready;
  logic        o_done;
  logic        o_err;

  int n_checks = 0;
  int n_errors = 0;
  bit exp_q[$];

  always #5 i_clk = ~i_clk;

  ir_tx_sequencer #(.P_HALF(32), .P_SHORT(32), .P_LONG(64)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_start      (i_start),
    .i_mode       (i_mode),
    .i_data       (i_data),
    .i_nbits      (i_nbits),
    .i_carrier_div(i_carrier_div),
    .i_abort      (i_abort),
    .o_ir_dout    (o_ir_dout),
    .o_ready      (o_ready),
    .o_done       (o_done),
    .o_err        (o_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {28'd0, o_ready, o_done, o_err, o_ir_dout};
  endfunction

  task automatic add_seg(input bit mark, input int periods, input int d);
    for (int p = 0; p < periods * d; p++)
      exp_q.push_back(mark && ((p % d) < (d / 4)));
  endtask

  // Expected o_ir_dout for each cycle of the frame, starting at cycle 1.
  task automatic build_model(input int mode, input logic [31:0] data, input int nbits, input int div);
    int n;
    int d;
    bit v;
    n = (nbits > 32) ? 32 : nbits;
    d = (div < 4) ? 4 : div;
    exp_q.delete();
    for (int b = 0; b < n; b++) begin
      v = data[b];
      case (mode)
        0: begin
          add_seg(!v, T_HALF, d);
          add_seg(v, T_HALF, d);
        end
        1: begin
          add_seg(1'b1, T_SHORT, d);
          add_seg(1'b0, v ? T_LONG : T_SHORT, d);
        end
        default: begin
          add_seg(1'b1, v ? T_LONG : T_SHORT, d);
          add_seg(1'b0, T_SHORT, d);
        end
      endcase
    end
  endtask

  task automatic scramble();
    i_data        = $urandom;
    i_mode        = 2'($urandom);
    i_nbits       = 6'($urandom);
    i_carrier_div = 16'($urandom);
    i_start       = 1'($urandom);
  endtask

  // Called at a negedge; request goes in on the next rising edge.
  task automatic run_frame(input int mode, input logic [31:0] data, input int nbits,
                           input int div, input string name);
    int len;
    logic [31:0] exp;
    build_model(mode, data, nbits, div);
    len           = exp_q.size();
    i_start       = 1'b1;
    i_mode        = mode[1:0];
    i_data        = data;
    i_nbits       = nbits[5:0];
    i_carrier_div = div[15:0];
    @(posedge i_clk);
    for (int k = 1; k <= len + 2; k++) begin
      @(negedge i_clk);
      if (k <= len)         exp = {31'd0, exp_q[k-1]};
      else if (k == len + 1) exp = 32'h4;
      else                   exp = 32'h8;
      chk($sformatf("%s@%0d", name, k), outs(), exp);
      if (k < len + 2) scramble();
      else i_start = 1'b0;
    end
  endtask

  initial begin
    i_rst_n       = 1'b0;
    i_start       = 1'b0;
    i_mode        = 2'd0;
    i_data        = 32'd0;
    i_nbits       = 6'd0;
    i_carrier_div = 16'd0;
    i_abort       = 1'b0;
    repeat (2) @(negedge i_clk);
    chk("reset_state", outs(), 32'h8);
    i_rst_n = 1'b1;

    run_frame(0, 32'h1, 1, 8, "biphase");
    run_frame(1, 32'h2, 2, 8, "pdist");
    run_frame(2, 32'h1, 1, 4, "plen");

    // Illegal mode request.
    i_start = 1'b1;
    i_mode  = 2'd3;
    i_nbits = 6'd4;
    i_carrier_div = 16'd8;
    @(posedge i_clk);
    @(negedge i_clk);
    chk("illegal_err", outs(), 32'hA);
    i_start = 1'b0;
    @(negedge i_clk);
    chk("illegal_after", outs(), 32'h8);

    run_frame(2, $urandom, 40, 2, "clamp");

    for (int f = 0; f < 8; f++)
      run_frame(int'($urandom_range(0, 2)), $urandom, int'($urandom_range(0, 5)),
                int'($urandom_range(0, 7)), $sformatf("rand%0d", f));

    // Abort part-way through a bi-phase frame.
    build_model(0, 32'hA5, 8, 8);
    i_start = 1'b1;
    i_mode  = 2'd0;
    i_data  = 32'hA5;
    i_nbits = 6'd8;
    i_carrier_div = 16'd8;
    @(posedge i_clk);
    for (int k = 1; k <= 100; k++) begin
      @(negedge i_clk);
      chk($sformatf("abort_pre@%0d", k), outs(), {31'd0, exp_q[k-1]});
      scramble();
    end
    i_abort = 1'b1;
    @(negedge i_clk);
    chk("abort_idle", outs(), 32'h8);
    i_abort = 1'b0;
    i_start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge i_clk);
      chk($sformatf("abort_nodone%0d", k), outs(), 32'h8);
    end

    // Reset during a mark, then an immediate mode-1 frame.
    i_start = 1'b1;
    i_mode  = 2'd0;
    i_data  = 32'h0;
    i_nbits = 6'd4;
    i_carrier_div = 16'd8;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    chk("rst_mark", outs(), 32'h1);
    i_rst_n = 1'b0;
    #1;
    chk("rst_async", outs(), 32'h8);
    @(negedge i_clk);
    chk("rst_hold", outs(), 32'h8);
    i_rst_n = 1'b1;
    run_frame(1, $urandom, 3, 5, "post_rst");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ir_tx_sequencer.md
IR_TX_SEQUENCER -- requirements
Module: ir_tx_sequencer

Interface
REQ-001 Parameters SHALL be: P_HALF 32, bi-phase half-bit length in carrier periods; P_SHORT 32, short segment length in carrier periods; P_LONG 64, long segment length in carrier periods.
REQ-002 i_clk  input  1  system clock; all flops SHALL be on the rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_start  input  1  frame request, sampled only when o_ready=1.
REQ-005 i_mode  input  2  coding mode: 0 bi-phase, 1 pulse-distance, 2 pulse-length, 3 illegal.
REQ-006 i_data  input  32  frame payload, transmitted LSB first.
REQ-007 i_nbits  input  6  number of bits to send; values above 32 SHALL be clamped to 32.
REQ-008 i_carrier_div  input  16  carrier period in i_clk cycles; values below 4 SHALL be treated as 4.
REQ-009 i_abort  input  1  synchronous frame abort.
REQ-010 o_ir_dout  output  1  modulated IR output.
REQ-011 o_ready  output  1  high exactly when the FSM is in IDLE.
REQ-012 o_done  output  1  one-cycle pulse at the end of a frame.
REQ-013 o_err  output  1  one-cycle pulse when a request with i_mode=3 is rejected.

Function
REQ-014 The FSM SHALL have states IDLE, SEG1, SEG2 and DONE.
REQ-015 On i_start&&o_ready with i_mode<3, the block SHALL capture mode, data, clamped nbits and clamped div.
REQ-016 On that capture, the FSM SHALL enter SEG1 on the next cycle, with the carrier counter and the segment counter both cleared.
REQ-017 On i_start&&o_ready with i_mode=3, o_err SHALL pulse on the next cycle and the FSM SHALL remain in IDLE.
REQ-018 On i_start&&o_ready with nbits=0, the FSM SHALL go directly to DONE.
REQ-019 The carrier SHALL have period div cycles and SHALL be high for counts 0..div/4-1 (integer division), low otherwise.
REQ-020 A period tick SHALL occur when the carrier count equals div-1, after which the count wraps to 0.
REQ-021 Mark segment: o_ir_dout SHALL equal the carrier; space segment: o_ir_dout SHALL be 0.
REQ-022 A segment SHALL end on its Nth period tick; the next segment SHALL start on the following cycle with the carrier count at 0.
REQ-023 Bi-phase bit 0 SHALL be mark then space, and bit 1 SHALL be space then mark, each P_HALF periods.
REQ-024 Pulse-distance SHALL send a mark of P_SHORT, then a space of P_SHORT for bit 0 or P_LONG for bit 1.
REQ-025 Pulse-length SHALL send a mark of P_SHORT for bit 0 or P_LONG for bit 1, then a space of P_SHORT.
REQ-026 At the end of SEG2 the shift register SHALL shift right by 1 and the bit counter SHALL decrement.
REQ-027 At the end of SEG2 the FSM SHALL go to SEG1 if bits remain, else to DONE.
REQ-028 DONE SHALL last one cycle with o_done=1, then the FSM SHALL return to IDLE.
REQ-029 o_ir_dout SHALL be 0 in IDLE and DONE.
REQ-030 i_start SHALL be ignored while o_ready=0.
REQ-031 Input changes during a frame SHALL have no effect.
REQ-032 i_abort in SEG1 or SEG2 SHALL return the FSM to IDLE on the next cycle with o_ir_dout=0 and no o_done.
REQ-033 i_abort SHALL take priority over a simultaneous segment end.
REQ-034 Segment counters SHALL be 7 bits wide; the carrier counter SHALL be 16 bits wide; no counter SHALL overflow for legal parameters.

Reset
REQ-035 While i_rst_n=0, the FSM SHALL be in IDLE, all counters and captured registers SHALL be 0, o_ir_dout=0, o_done=0, o_err=0 and o_ready=1.
REQ-036 Reset asserted mid-frame SHALL force o_ir_dout low immediately, without waiting for a clock edge.
REQ-037 The first request SHALL be accepted on the first rising edge after deassertion.

Structure
REQ-038 Package ir_tx_pkg SHALL hold the mode enum, the FSM state enum, the minimum-div constant 4 and the maximum-bit constant 32.
REQ-039 Sub-module ir_carrier_gen SHALL contain the carrier counter, the duty compare and the period tick, with a synchronous clear input.

Verification
REQ-040 Bi-phase: div=8, mode 0, data=0x1, nbits=1 -> space for cycles 1-256, then mark cycles 257-512 with the pattern 2 high/6 low; o_done at cycle 513; o_ready at cycle 514.
REQ-041 Pulse-distance: div=8, mode 1, data=0x2, nbits=2 -> bit0 mark 256 + space 256 cycles; bit1 mark 256 + space 512 cycles; o_done at cycle 1281.
REQ-042 Pulse-length: div=4, mode 2, data=0x1, nbits=1 -> mark 256 cycles with the pattern 1 high/3 low, then space 128 cycles; o_done at cycle 385.
REQ-043 Illegal and clamp: mode 3 -> o_err at cycle 1 and o_ready stays 1; div=2, nbits=40 -> carrier period of 4 cycles and 32 bits sent.
REQ-044 Abort: i_abort at cycle 100 of a mode-0 frame -> o_ir_dout=0 and o_ready=1 at cycle 101, with no o_done.
REQ-045 Reset mid-frame: i_rst_n low during a mark -> o_ir_dout drops with no clock; after release, a new mode-1 frame completes correctly.
